seq_divider: RTL

//  Iterative radix-2 restoring divider; inverse of the 12x12 multiplier datapath.

---
 rtl/seq_divider_pkg.sv | 23 ++
 rtl/seq_divider_div_step.sv | 29 ++
 rtl/seq_divider.sv | 128 ++++++++++++
 3 files changed

// File: rtl/seq_divider_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_pkg
// Brief    : Shared state encodings, default widths and helpers for seq_divider
// Revision : 1.0 - initial release
// ============================================================================
package seq_divider_pkg;

    localparam int c_dw_a_default = 24;
    localparam int c_dw_b_default = 12;

    localparam int                   c_state_w = 2;
    localparam logic [c_state_w-1:0] c_st_idle = 2'd0;
    localparam logic [c_state_w-1:0] c_st_run  = 2'd1;
    localparam logic [c_state_w-1:0] c_st_done = 2'd2;

    // Step counter width; never below one bit.
    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_divider_div_step.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider_div_step
// Brief    : Combinational one-bit restoring division step
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider_div_step #(
    parameter int DW_B = 12
) (
    input  logic [DW_B:0]   rem_in,
    input  logic            bit_in,
    input  logic [DW_B-1:0] b,
    output logic [DW_B-1:0] rem_out,
    output logic            q_bit
);

    logic [DW_B+1:0] w_shifted;
    logic [DW_B+1:0] w_diff;
    logic            w_unused;

    assign w_shifted = {rem_in, bit_in};
    assign w_diff    = w_shifted - {2'b00, b};
    assign q_bit     = (w_shifted >= {2'b00, b});
    // A restored remainder is always below b, so it fits in DW_B bits.
    assign rem_out   = q_bit ? w_diff[DW_B-1:0] : w_shifted[DW_B-1:0];
    assign w_unused  = ^{w_diff[DW_B+1:DW_B], w_shifted[DW_B+1:DW_B]};

endmodule
`default_nettype wire

// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Iterative radix-2 restoring divider, one quotient bit per clock,
//            valid/ready on both sides. Optional macro DIV_BYZERO_EN adds a
//            div0 flag and a single-cycle divide-by-zero shortcut.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int DW_A = c_dw_a_default,
    parameter int DW_B = c_dw_b_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW_A-1:0] a,
    input  logic [DW_B-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW_A-1:0] q,
    output logic [DW_B-1:0] r
`ifdef DIV_BYZERO_EN
    ,
    output logic            div0
`endif
);

    localparam int                 c_cnt_w    = cnt_width(DW_A);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(DW_A - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    logic [c_state_w-1:0] r_state;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic [DW_A-1:0]      r_quo;
    logic [DW_B-1:0]      r_rem;
    logic [DW_B-1:0]      r_b;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [DW_B-1:0]      w_rem_next;
    logic                 w_q_bit;

    // The dividend shifts out of the MSB while quotient bits shift into the LSB.
    seq_divider_div_step #(
        .DW_B (DW_B)
    ) u_step (
        .rem_in  ({1'b0, r_rem}),
        .bit_in  (r_quo[DW_A-1]),
        .b       (r_b),
        .rem_out (w_rem_next),
        .q_bit   (w_q_bit)
    );

`ifdef DIV_BYZERO_EN
    logic r_div0;
    assign div0 = r_div0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_quo       <= '0;
            r_rem       <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
`ifdef DIV_BYZERO_EN
            r_div0      <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_in_ready <= 1'b1;
                    if (in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_quo      <= a;
                        r_rem      <= '0;
                        r_b        <= b;
                        r_cnt      <= c_cnt_load;
                        r_state    <= c_st_run;
`ifdef DIV_BYZERO_EN
                        r_div0     <= 1'b0;
                        if (b == '0) begin
                            r_quo       <= '1;
                            r_rem       <= a[DW_B-1:0];
                            r_div0      <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= c_st_done;
                        end
`endif
                    end
                end
                c_st_run: begin
                    r_quo <= {r_quo[DW_A-2:0], w_q_bit};
                    r_rem <= w_rem_next;
                    if (r_cnt == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_one;
                    end
                end
                c_st_done: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= c_st_idle;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign q         = r_quo;
    assign r         = r_rem;

endmodule
`default_nettype wire
